flash_cmd_ctrl: RTL and testbench

Byte-level flash command sequencer that sits directly upstream of the bit-level SPI flash controller. It turns host requests (read, page program, sector erase, read status) into ordered byte requests with deselect control. It also runs the write-enable prefix and the write-in-progress status polling. It owns no SPI pins; all flash traffic passes through the downstream byte interface.

---
 rtl/flash_pkg.sv | 37 +++
 rtl/flash_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_flash_cmd_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared opcodes, command encodings and FSM state type for the flash command sequencer.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam logic [1:0] CMD_READ    = 2'd0;
  localparam logic [1:0] CMD_PROGRAM = 2'd1;
  localparam logic [1:0] CMD_ERASE   = 2'd2;
  localparam logic [1:0] CMD_RDSR    = 2'd3;

  localparam int unsigned LEN_W   = 9;
  localparam int unsigned POLL_W  = 32;
  localparam logic [LEN_W-1:0] LEN_MAX = 9'd256;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WREN, ST_OPC, ST_A2, ST_A1, ST_A0,
    ST_RD_DATA, ST_WR_DATA, ST_POLL_OPC, ST_POLL_RD, ST_FINISH, ST_WAIT
  } state_e;

  // What to do with spi_dout when the pending byte completes
  typedef enum logic [1:0] {RK_NONE, RK_DATA, RK_STAT, RK_POLL} rd_kind_e;

  // Main opcode sent in the OPC byte for each command
  function automatic logic [7:0] cmd_opcode(input logic [1:0] c);
    case (c)
      CMD_READ:    return OP_READ;
      CMD_PROGRAM: return OP_PP;
      CMD_ERASE:   return OP_SE;
      default:     return OP_RDSR;
    endcase
  endfunction

endpackage

// File: rtl/flash_cmd_ctrl.sv
// Byte-level flash command sequencer: turns host commands into byte requests
// for the downstream SPI byte controller, with WREN prefix and WIP polling.
module flash_cmd_ctrl
  import flash_pkg::*;
#(
  parameter logic [23:0] POLL_MAX = 24'd4_000_000,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        wr_data,
  output logic              wr_data_rd,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              cmd_done,
  output logic              error,
  output logic [7:0]        status,
  output logic              spi_write,
  output logic              spi_read,
  output logic              spi_deselect,
  output logic [7:0]        spi_din,
  input  logic [7:0]        spi_dout,
  input  logic              spi_done
);

  state_e             state;
  state_e             ret_state;
  rd_kind_e           rd_kind;
  logic [1:0]         cmd_q;
  logic [23:0]        addr_q;
  logic [LEN_W-1:0]   cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic               err_flag;
  logic               last_byte;

  assign last_byte = (cnt == 9'd1);

  // Sequencer: each byte state issues one request and parks in ST_WAIT until spi_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      rd_kind      <= RK_NONE;
      cmd_q        <= 2'd0;
      addr_q       <= 24'd0;
      cnt          <= '0;
      poll_cnt     <= '0;
      err_flag     <= 1'b0;
      wr_data_rd   <= 1'b0;
      rd_data      <= 8'd0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      cmd_done     <= 1'b0;
      error        <= 1'b0;
      status       <= 8'd0;
      spi_write    <= 1'b0;
      spi_read     <= 1'b0;
      spi_deselect <= 1'b0;
      spi_din      <= 8'd0;
    end else begin
      spi_write  <= 1'b0;
      spi_read   <= 1'b0;
      wr_data_rd <= 1'b0;
      rd_valid   <= 1'b0;
      cmd_done   <= 1'b0;
      error      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            cmd_q    <= cmd;
            addr_q   <= 24'(addr);
            cnt      <= len;
            poll_cnt <= '0;
            err_flag <= 1'b0;
            busy     <= 1'b1;
            if ((cmd == CMD_READ || cmd == CMD_PROGRAM) &&
                (len == 9'd0 || len > LEN_MAX)) begin
              err_flag <= 1'b1;
              state    <= ST_FINISH;
            end else begin
              case (cmd)
                CMD_READ: state <= ST_OPC;
                CMD_RDSR: state <= ST_POLL_OPC;
                default:  state <= ST_WREN;
              endcase
            end
          end
        end

        ST_WREN: begin
          spi_write    <= 1'b1;
          spi_din      <= OP_WREN;
          spi_deselect <= 1'b1;
          rd_kind      <= RK_NONE;
          ret_state    <= ST_OPC;
          state        <= ST_WAIT;
        end

        ST_OPC: begin
          spi_write    <= 1'b1;
          spi_din      <= cmd_opcode(cmd_q);
          spi_deselect <= 1'b0;
          rd_kind      <= RK_NONE;
          ret_state    <= ST_A2;
          state        <= ST_WAIT;
        end

        ST_A2: begin
          spi_write    <= 1'b1;
          spi_din      <= addr_q[23:16];
          spi_deselect <= 1'b0;
          rd_kind      <= RK_NONE;
          ret_state    <= ST_A1;
          state        <= ST_WAIT;
        end

        ST_A1: begin
          spi_write    <= 1'b1;
          spi_din      <= addr_q[15:8];
          spi_deselect <= 1'b0;
          rd_kind      <= RK_NONE;
          ret_state    <= ST_A0;
          state        <= ST_WAIT;
        end

        // Erase ends its frame on the last address byte; read/program continue with data
        ST_A0: begin
          spi_write    <= 1'b1;
          spi_din      <= addr_q[7:0];
          spi_deselect <= (cmd_q == CMD_ERASE);
          rd_kind      <= RK_NONE;
          case (cmd_q)
            CMD_READ:    ret_state <= ST_RD_DATA;
            CMD_PROGRAM: ret_state <= ST_WR_DATA;
            default:     ret_state <= ST_POLL_OPC;
          endcase
          state <= ST_WAIT;
        end

        ST_RD_DATA: begin
          spi_read     <= 1'b1;
          spi_din      <= 8'd0;
          spi_deselect <= last_byte;
          cnt          <= cnt - 9'd1;
          rd_kind      <= RK_DATA;
          ret_state    <= last_byte ? ST_FINISH : ST_RD_DATA;
          state        <= ST_WAIT;
        end

        ST_WR_DATA: begin
          spi_write    <= 1'b1;
          spi_din      <= wr_data;
          wr_data_rd   <= 1'b1;
          spi_deselect <= last_byte;
          cnt          <= cnt - 9'd1;
          rd_kind      <= RK_NONE;
          ret_state    <= last_byte ? ST_POLL_OPC : ST_WR_DATA;
          state        <= ST_WAIT;
        end

        ST_POLL_OPC: begin
          spi_write    <= 1'b1;
          spi_din      <= OP_RDSR;
          spi_deselect <= 1'b0;
          rd_kind      <= RK_NONE;
          ret_state    <= ST_POLL_RD;
          state        <= ST_WAIT;
        end

        // Same RDSR read serves both READ_STATUS and the WIP poll loop
        ST_POLL_RD: begin
          spi_read     <= 1'b1;
          spi_din      <= 8'd0;
          spi_deselect <= 1'b1;
          rd_kind      <= (cmd_q == CMD_RDSR) ? RK_STAT : RK_POLL;
          ret_state    <= ST_FINISH;
          state        <= ST_WAIT;
        end

        ST_WAIT: begin
          if (spi_done) begin
            state <= ret_state;
            case (rd_kind)
              RK_DATA: begin
                rd_data  <= spi_dout;
                rd_valid <= 1'b1;
              end
              RK_STAT: begin
                rd_data  <= spi_dout;
                rd_valid <= 1'b1;
                status   <= spi_dout;
              end
              RK_POLL: begin
                status   <= spi_dout;
                poll_cnt <= poll_cnt + 32'd1;
                if (!spi_dout[0]) begin
                  state <= ST_FINISH;
                end else if (poll_cnt + 32'd1 == 32'(POLL_MAX)) begin
                  err_flag <= 1'b1;
                  state    <= ST_FINISH;
                end else begin
                  state <= ST_POLL_OPC;
                end
              end
              default: ;
            endcase
          end
        end

        ST_FINISH: begin
          cmd_done <= 1'b1;
          error    <= err_flag;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_ctrl.sv
// Self-checking bench: byte-controller/flash model plus table-driven command vectors.
module tb_flash_cmd_ctrl;
  import flash_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [1:0]  cmd;
  logic [23:0] addr;
  logic [8:0]  len;
  logic [7:0]  wr_data;
  logic        wr_data_rd;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        cmd_done;
  logic        error;
  logic [7:0]  status;
  logic        spi_write;
  logic        spi_read;
  logic        spi_deselect;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout;
  logic        spi_done;

  flash_cmd_ctrl #(.POLL_MAX(24'd5), .ADDR_W(24)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd(cmd), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .cmd_done(cmd_done), .error(error), .status(status),
    .spi_write(spi_write), .spi_read(spi_read), .spi_deselect(spi_deselect),
    .spi_din(spi_din), .spi_dout(spi_dout), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state (written only by the model process)
  logic [9:0] req_log[$];   // {is_write, deselect, byte}; reads log byte 00
  logic [7:0] rd_log[$];
  int         n_wrrd, n_done, proto_bad, wip_left, txn_idx, data_ptr, src_idx, dly;
  logic       last_err, pend, prev_strobe;
  logic [7:0] txn_op, resp;

  // Configuration written by the stimulus process
  logic       tb_clear;
  int         wip_cfg;
  logic [7:0] mem[256];
  logic [7:0] src[4];

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 4; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    src[0] = 8'hAA; src[1] = 8'h55; src[2] = 8'hC3; src[3] = 8'h3C;
  end

  // Byte controller + flash model: accepts a strobe, answers with spi_done two cycles later
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      spi_done = 1'b0; spi_dout = 8'h00; pend = 1'b0; dly = 0;
      prev_strobe = 1'b0; txn_idx = 0; wr_data = 8'h00;
    end else begin
      spi_done = 1'b0;
      if (tb_clear) begin
        req_log.delete(); rd_log.delete();
        n_wrrd = 0; n_done = 0; proto_bad = 0; last_err = 1'b0;
        wip_left = wip_cfg; data_ptr = 0; txn_idx = 0; txn_op = 8'h00;
        src_idx = 0; wr_data = src[0];
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if (wr_data_rd) begin
        n_wrrd++; src_idx++;
        wr_data = (src_idx < 4) ? src[src_idx] : 8'h00;
      end
      if (cmd_done) begin n_done++; last_err = error; end
      if (spi_write || spi_read) begin
        if (spi_write && spi_read) proto_bad++;
        if (prev_strobe) proto_bad++;
        if (pend) proto_bad++;
        req_log.push_back({spi_write, spi_deselect, spi_write ? spi_din : 8'h00});
        if (spi_write) begin
          if (txn_idx == 0) txn_op = spi_din;
          resp = 8'h00;
        end else if (txn_op == OP_READ) begin
          resp = mem[data_ptr % 256]; data_ptr++;
        end else if (txn_op == OP_RDSR) begin
          resp = (wip_left > 0) ? 8'h01 : 8'h00;
          if (wip_left > 0) wip_left--;
        end else begin
          resp = 8'hFF;
        end
        txn_idx = spi_deselect ? 0 : txn_idx + 1;
        pend = 1'b1; dly = 2;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin spi_done = 1'b1; spi_dout = resp; pend = 1'b0; end
      end
      prev_strobe = spi_write || spi_read;
    end
  end

  typedef struct {
    int          id;
    logic [1:0]  c;
    logic [23:0] a;
    logic [8:0]  l;
    int          wip;
    int          req_start;
    int          req_n;
    logic        exp_err;
    int          exp_nrd;
    logic [31:0] exp_rd;     // first read byte in bits [7:0]
    int          exp_nwr;
    bit          chk_status;
    logic [7:0]  exp_status;
  } vec_t;

  vec_t       vecs[8];
  logic [9:0] exp_all[$];

  function automatic logic [9:0] ew(input logic [7:0] b, input logic d);
    return {1'b1, d, b};
  endfunction
  function automatic logic [9:0] er(input logic d);
    return {1'b0, d, 8'h00};
  endfunction

  task automatic check(input string what, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %0h, expected %0h", what, id, act, exp);
    end
  endtask

  task automatic check_outs_zero(input string what);
    check(what, -1, {busy, spi_write, spi_read, spi_deselect, spi_din, cmd_done, error,
                     status, rd_valid, rd_data, wr_data_rd}, 32'h0);
  endtask

  task automatic setup(input int wip);
    @(posedge clk); #1;
    wip_cfg = wip; tb_clear = 1'b1;
    @(negedge clk); #1;
    tb_clear = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] c, input logic [23:0] a, input logic [8:0] l);
    @(posedge clk); #1;
    cmd = c; addr = a; len = l; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      @(posedge clk); i++;
    end
    #1;
  endtask

  task automatic compare_vec(input vec_t v);
    check("cmd_done count", v.id, n_done, 1);
    check("error flag", v.id, 32'(last_err), 32'(v.exp_err));
    check("request count", v.id, req_log.size(), v.req_n);
    for (int i = 0; i < v.req_n && i < req_log.size(); i++)
      check($sformatf("request[%0d]", i), v.id, 32'(req_log[i]), 32'(exp_all[v.req_start + i]));
    check("rd_valid count", v.id, rd_log.size(), v.exp_nrd);
    for (int i = 0; i < v.exp_nrd && i < 4 && i < rd_log.size(); i++)
      check($sformatf("rd_data[%0d]", i), v.id, 32'(rd_log[i]), 32'(v.exp_rd[i*8 +: 8]));
    check("wr_data_rd count", v.id, n_wrrd, v.exp_nwr);
    if (v.chk_status) check("status", v.id, 32'(status), 32'(v.exp_status));
    check("protocol violations", v.id, proto_bad, 0);
    check("busy after done", v.id, 32'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    setup(v.wip);
    start_cmd(v.c, v.a, v.l);
    wait_done(5000);
    repeat (5) @(posedge clk);
    #1;
    compare_vec(v);
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd = 2'd0; addr = 24'd0; len = 9'd0;
    tb_clear = 1'b0; wip_cfg = 0;

    // Vector table with hand-computed byte streams
    vecs[0] = '{id:0, c:CMD_READ, a:24'h012345, l:9'd4, wip:0, req_start:exp_all.size(), req_n:8,
                exp_err:1'b0, exp_nrd:4, exp_rd:32'h44332211, exp_nwr:0, chk_status:0, exp_status:8'h00};
    exp_all.push_back(ew(8'h03, 0)); exp_all.push_back(ew(8'h01, 0));
    exp_all.push_back(ew(8'h23, 0)); exp_all.push_back(ew(8'h45, 0));
    exp_all.push_back(er(0)); exp_all.push_back(er(0)); exp_all.push_back(er(0)); exp_all.push_back(er(1));

    vecs[1] = '{id:1, c:CMD_PROGRAM, a:24'h000100, l:9'd2, wip:3, req_start:exp_all.size(), req_n:15,
                exp_err:1'b0, exp_nrd:0, exp_rd:32'h0, exp_nwr:2, chk_status:1, exp_status:8'h00};
    exp_all.push_back(ew(8'h06, 1)); exp_all.push_back(ew(8'h02, 0));
    exp_all.push_back(ew(8'h00, 0)); exp_all.push_back(ew(8'h01, 0)); exp_all.push_back(ew(8'h00, 0));
    exp_all.push_back(ew(8'hAA, 0)); exp_all.push_back(ew(8'h55, 1));
    for (int k = 0; k < 4; k++) begin exp_all.push_back(ew(8'h05, 0)); exp_all.push_back(er(1)); end

    vecs[2] = '{id:2, c:CMD_ERASE, a:24'h020000, l:9'd0, wip:1000, req_start:exp_all.size(), req_n:15,
                exp_err:1'b1, exp_nrd:0, exp_rd:32'h0, exp_nwr:0, chk_status:1, exp_status:8'h01};
    exp_all.push_back(ew(8'h06, 1)); exp_all.push_back(ew(8'hD8, 0));
    exp_all.push_back(ew(8'h02, 0)); exp_all.push_back(ew(8'h00, 0)); exp_all.push_back(ew(8'h00, 1));
    for (int k = 0; k < 5; k++) begin exp_all.push_back(ew(8'h05, 0)); exp_all.push_back(er(1)); end

    vecs[3] = '{id:3, c:CMD_RDSR, a:24'h0, l:9'd0, wip:1, req_start:exp_all.size(), req_n:2,
                exp_err:1'b0, exp_nrd:1, exp_rd:32'h01, exp_nwr:0, chk_status:1, exp_status:8'h01};
    exp_all.push_back(ew(8'h05, 0)); exp_all.push_back(er(1));

    vecs[4] = '{id:4, c:CMD_READ, a:24'h000010, l:9'd0, wip:0, req_start:exp_all.size(), req_n:0,
                exp_err:1'b1, exp_nrd:0, exp_rd:32'h0, exp_nwr:0, chk_status:0, exp_status:8'h00};

    vecs[5] = '{id:5, c:CMD_PROGRAM, a:24'h000200, l:9'd300, wip:0, req_start:exp_all.size(), req_n:0,
                exp_err:1'b1, exp_nrd:0, exp_rd:32'h0, exp_nwr:0, chk_status:0, exp_status:8'h00};

    vecs[6] = '{id:6, c:CMD_READ, a:24'hFFFFFF, l:9'd1, wip:0, req_start:exp_all.size(), req_n:5,
                exp_err:1'b0, exp_nrd:1, exp_rd:32'h11, exp_nwr:0, chk_status:0, exp_status:8'h00};
    exp_all.push_back(ew(8'h03, 0)); exp_all.push_back(ew(8'hFF, 0));
    exp_all.push_back(ew(8'hFF, 0)); exp_all.push_back(ew(8'hFF, 0)); exp_all.push_back(er(1));

    vecs[7] = '{id:7, c:CMD_RDSR, a:24'h0, l:9'd0, wip:0, req_start:exp_all.size(), req_n:2,
                exp_err:1'b0, exp_nrd:1, exp_rd:32'h00, exp_nwr:0, chk_status:1, exp_status:8'h00};
    exp_all.push_back(ew(8'h05, 0)); exp_all.push_back(er(1));

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset outputs");
    @(negedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bad length: busy one cycle, then cmd_done+error with busy low
    setup(0);
    start_cmd(CMD_READ, 24'h000000, 9'd0);
    check("badlen busy", 10, 32'(busy), 1);
    check("badlen early done", 10, 32'(cmd_done), 0);
    @(posedge clk); #1;
    check("badlen done", 10, {30'd0, cmd_done, error}, 32'h3);
    check("badlen busy low", 10, 32'(busy), 0);
    @(posedge clk); #1;
    check("badlen done pulse", 10, 32'(cmd_done), 0);
    check("badlen traffic", 10, req_log.size(), 0);

    // cmd_start while busy is ignored
    setup(0);
    start_cmd(CMD_READ, 24'h012345, 9'd4);
    repeat (6) @(posedge clk);
    #1;
    check("ignore busy", 11, 32'(busy), 1);
    cmd = CMD_PROGRAM; addr = 24'h000000; len = 9'd5; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    wait_done(5000);
    repeat (30) @(posedge clk);
    #1;
    compare_vec(vecs[0]);

    // Reset during the A1 byte, then a clean READ
    setup(0);
    start_cmd(CMD_READ, 24'h012345, 9'd4);
    for (int i = 0; i < 200 && req_log.size() < 3; i++) @(posedge clk);
    check("a1 reached", 12, 32'(req_log.size() >= 3), 1);
    if (req_log.size() >= 3) check("a1 byte", 12, 32'(req_log[2]), 32'(ew(8'h23, 0)));
    #2;
    reset = 1'b1;
    #1;
    check_outs_zero("async reset outputs");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    run_vec(vecs[0]);

    // Maximum length READ
    setup(0);
    start_cmd(CMD_READ, 24'h000000, 9'd256);
    wait_done(5000);
    repeat (5) @(posedge clk);
    #1;
    check("len256 done", 13, n_done, 1);
    check("len256 error", 13, 32'(last_err), 0);
    check("len256 requests", 13, req_log.size(), 260);
    check("len256 reads", 13, rd_log.size(), 256);
    if (rd_log.size() == 256) check("len256 last byte", 13, 32'(rd_log[255]), 32'(mem[255]));
    begin
      int nd = 0;
      foreach (req_log[i]) if (req_log[i][8]) nd++;
      check("len256 deselects", 13, nd, 1);
    end
    if (req_log.size() == 260) check("len256 final req", 13, 32'(req_log[259]), 32'(er(1)));
    check("len256 protocol", 13, proto_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
